pipeline_controller: RTL

Pipelined control unit for the 5-stage RV32I core. It decodes the instruction in Decode. It then carries the control word through the ID/EX, EX/MEM (MEM_LAT deep) and MEM/WB pipeline registers, and resolves PCSrc in Execute for all six branch conditions plus JAL/JALR. Bubble insertion on FlushE is handled internally. The hazard unit consumes the stage-tagged RegWrite/ResultSrc outputs for forwarding and load-use detection.

---
 rtl/riscv_ctrl_pkg.sv | 77 +++++++
 rtl/ctrl_decoder.sv | 107 ++++++++++
 rtl/pipeline_controller.sv | 121 ++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - encodings and control-word types for the RV32I pipeline controller
package riscv_ctrl_pkg;

    // Opcodes the decoder recognises; anything else is illegal
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_SLT  = 4'b0100,
        ALU_XOR  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SLL  = 4'b1010,
        ALU_SLTU = 4'b1011
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // Branch conditions; 010/011 are reserved and never taken
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Everything ID/EX carries into Execute
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [3:0] alu_control;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] funct3;
    } ctrl_word_t;

    localparam ctrl_word_t BUBBLE = '0;

    // Fields that survive past the first MEM stage (MemWrite is dropped there)
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational main and ALU decoder for the Decode stage
module ctrl_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_BUBBLE = 1'b1
) (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output ctrl_word_t ctrl,
    output logic [2:0] imm_src,
    output logic       illegal
);

    ctrl_word_t main_ctrl;
    logic [1:0] alu_op;
    logic [3:0] alu_control;
    logic       legal;

    // Main decoder: per-opcode control fields, immediate format and ALU class
    always_comb begin
        main_ctrl = BUBBLE;
        alu_op    = ALUOP_ADD;
        imm_src   = IMM_I;
        legal     = 1'b1;
        case (op)
            OP_R: begin
                main_ctrl.reg_write = 1'b1;
                alu_op              = ALUOP_FUNCT;
            end
            OP_I: begin
                main_ctrl.reg_write = 1'b1;
                main_ctrl.alu_src_b = 1'b1;
                alu_op              = ALUOP_FUNCT;
            end
            OP_LOAD: begin
                main_ctrl.reg_write  = 1'b1;
                main_ctrl.result_src = RES_MEM;
                main_ctrl.alu_src_b  = 1'b1;
            end
            OP_STORE: begin
                main_ctrl.mem_write = 1'b1;
                main_ctrl.alu_src_b = 1'b1;
                imm_src             = IMM_S;
            end
            OP_BRANCH: begin
                main_ctrl.branch = 1'b1;
                alu_op           = ALUOP_SUB;
                imm_src          = IMM_B;
            end
            OP_JAL: begin
                main_ctrl.jump       = 1'b1;
                main_ctrl.reg_write  = 1'b1;
                main_ctrl.result_src = RES_PC4;
                imm_src              = IMM_J;
            end
            OP_JALR: begin
                main_ctrl.jump       = 1'b1;
                main_ctrl.jalr       = 1'b1;
                main_ctrl.reg_write  = 1'b1;
                main_ctrl.result_src = RES_PC4;
                main_ctrl.alu_src_b  = 1'b1;
            end
            OP_LUI: begin
                main_ctrl.reg_write = 1'b1;
                main_ctrl.alu_src_a = 1'b1;
                main_ctrl.alu_src_b = 1'b1;
                imm_src             = IMM_U;
            end
            default: legal = 1'b0;
        endcase
    end

    // ALU decoder: only R/I-type look at funct3; subtract needs R-type (op[5]) and instr[30]
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
        endcase
    end

    // Unsupported opcodes always yield an all-zero word; only the flag depends on the build
    always_comb begin
        ctrl = BUBBLE;
        if (legal) begin
            ctrl             = main_ctrl;
            ctrl.alu_control = alu_control;
            ctrl.funct3      = funct3;
        end
    end

    assign illegal = ILLEGAL_BUBBLE ? ~legal : 1'b0;

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - RV32I pipelined control unit: decode, stage registers, branch resolve
module pipeline_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_LAT        = 1,
    parameter bit ILLEGAL_BUBBLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       FlushE,
    input  logic       ZeroE,
    input  logic       LtE,
    input  logic       LtuE,
    output logic [2:0] ImmSrcD,
    output logic       IllegalD,
    output logic [3:0] ALUControlE,
    output logic       ALUSrcASelE,
    output logic       ALUSrcBSelE,
    output logic       JalrE,
    output logic       PCSrcE,
    output logic [1:0] ResultSrcE,
    output logic [1:0] ResultSrcM,
    output logic [1:0] ResultSrcW,
    output logic       RegWriteE,
    output logic       RegWriteM,
    output logic       RegWriteW,
    output logic       MemWriteM
);

    ctrl_word_t ctrl_d;
    ctrl_word_t ctrl_e;
    wb_ctrl_t   chain_q [MEM_LAT];
    logic       mem_write_m;
    wb_ctrl_t   wb_q;
    logic       taken;

    ctrl_decoder #(
        .ILLEGAL_BUBBLE(ILLEGAL_BUBBLE)
    ) u_decoder (
        .op      (op),
        .funct3  (funct3),
        .funct7b5(funct7b5),
        .ctrl    (ctrl_d),
        .imm_src (ImmSrcD),
        .illegal (IllegalD)
    );

    // ID/EX: a flush overrides whatever Decode produced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_e <= BUBBLE;
        end else if (FlushE) begin
            ctrl_e <= BUBBLE;
        end else begin
            ctrl_e <= ctrl_d;
        end
    end

    // First MEM stage: the only place MemWrite exists
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q[0]  <= '0;
            mem_write_m <= 1'b0;
        end else begin
            chain_q[0]  <= '{reg_write: ctrl_e.reg_write, result_src: ctrl_e.result_src};
            mem_write_m <= ctrl_e.mem_write;
        end
    end

    // Remaining MEM stages model data-memory latency
    for (genvar i = 1; i < MEM_LAT; i++) begin : g_chain
        // Shift write-back controls one stage deeper
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain_q[i] <= '0;
            end else begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    // MEM/WB captures the last MEM stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= chain_q[MEM_LAT-1];
        end
    end

    // Branch resolver: condition chosen by the funct3 carried into Execute
    always_comb begin
        taken = 1'b0;
        case (ctrl_e.funct3)
            F3_BEQ:  taken = ZeroE;
            F3_BNE:  taken = ~ZeroE;
            F3_BLT:  taken = LtE;
            F3_BGE:  taken = ~LtE;
            F3_BLTU: taken = LtuE;
            F3_BGEU: taken = ~LtuE;
            default: taken = 1'b0;
        endcase
    end

    assign PCSrcE      = ctrl_e.jump | (ctrl_e.branch & taken);
    assign ALUControlE = ctrl_e.alu_control;
    assign ALUSrcASelE = ctrl_e.alu_src_a;
    assign ALUSrcBSelE = ctrl_e.alu_src_b;
    assign JalrE       = ctrl_e.jalr;
    assign ResultSrcE  = ctrl_e.result_src;
    assign RegWriteE   = ctrl_e.reg_write;
    assign ResultSrcM  = chain_q[0].result_src;
    assign RegWriteM   = chain_q[0].reg_write;
    assign MemWriteM   = mem_write_m;
    assign ResultSrcW  = wb_q.result_src;
    assign RegWriteW   = wb_q.reg_write;

endmodule
